// File: rtl/data_gen_tx.sv
`default_nettype none
// ============================================================================
// data_gen_tx : valid/ready burst generator of incrementing or LFSR data words.
// Optional LFSR word mode is compiled in with DATA_GEN_TX_LFSR_EN.
// Revision: 1.0
// ============================================================================
module data_gen_tx #(
  parameter int CNT_W = 16,
  parameter int GAP_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [31:0]      seed_i,
  input  logic             mode_i,
  input  logic [GAP_W-1:0] gap_i,
  output logic [31:0]      data_out_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] sent_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic             r_valid, w_valid_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic [CNT_W-1:0] r_sent, w_sent_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic [GAP_W-1:0] r_gap, w_gap_nxt;
  logic [GAP_W-1:0] r_gap_cnt, w_gap_cnt_nxt;

  logic             w_mode;
  logic             w_xfer;
  logic [31:0]      w_first;
  logic [31:0]      w_step;
  logic [CNT_W-1:0] w_sent_inc;

`ifdef DATA_GEN_TX_LFSR_EN
  localparam logic [31:0] C_LFSR_TAPS = 32'h8020_0003;
  logic r_mode;

  assign w_mode = mode_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_mode <= 1'b0;
    end else if ((r_state == ST_IDLE) && start_i) begin
      r_mode <= w_mode;
    end
  end

  assign w_step = r_mode ? ({1'b0, r_data[31:1]} ^ (r_data[0] ? C_LFSR_TAPS : 32'h0))
                         : r_data + 32'd1;
`else
  // Mode is forced to incrementing; the read of mode_i keeps the port connected.
  assign w_mode = mode_i & 1'b0;
  assign w_step = r_data + 32'd1;
`endif

  // An all-zero LFSR state would lock up, so a zero seed starts from 1.
  assign w_first    = (w_mode && (seed_i == 32'h0)) ? 32'h1 : seed_i;
  assign w_xfer     = r_valid & ready_i;
  assign w_sent_inc = r_sent + CNT_W'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state   <= ST_IDLE;
      r_data    <= 32'h0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_sent    <= '0;
      r_count   <= '0;
      r_gap     <= '0;
      r_gap_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_sent    <= w_sent_nxt;
      r_count   <= w_count_nxt;
      r_gap     <= w_gap_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_data_nxt    = r_data;
    w_valid_nxt   = r_valid;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_sent_nxt    = r_sent;
    w_count_nxt   = r_count;
    w_gap_nxt     = r_gap;
    w_gap_cnt_nxt = r_gap_cnt;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_count_nxt = count_i;
          w_gap_nxt   = gap_i;
          w_sent_nxt  = '0;
          w_data_nxt  = w_first;
          w_busy_nxt  = 1'b1;
          if (count_i == '0) begin
            w_state_nxt = ST_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = ST_SEND;
            w_valid_nxt = 1'b1;
          end
        end
      end

      ST_SEND: begin
        // A transfer on the abort edge still counts.
        if (w_xfer) begin
          w_sent_nxt = w_sent_inc;
          w_data_nxt = w_step;
        end
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
          w_valid_nxt = 1'b0;
          w_busy_nxt  = 1'b0;
        end else if (w_xfer) begin
          if (w_sent_inc == r_count) begin
            w_state_nxt = ST_DONE;
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
          end else if (r_gap != '0) begin
            w_state_nxt   = ST_GAP;
            w_valid_nxt   = 1'b0;
            w_gap_cnt_nxt = r_gap - GAP_W'(1);
          end
        end
      end

      ST_GAP: begin
        if (abort_i) begin
          w_state_nxt = ST_IDLE;
          w_busy_nxt  = 1'b0;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = ST_SEND;
          w_valid_nxt = 1'b1;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_busy_nxt  = 1'b0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_valid_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  assign data_out_o = r_data;
  assign valid_o    = r_valid;
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign sent_o     = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_data_gen_tx.sv
`default_nettype none
// ============================================================================
// tb_data_gen_tx : self-checking bench for data_gen_tx (reference model plus
// directed bursts). Revision: 1.0
// ============================================================================
module tb_data_gen_tx;
  localparam int CNT_W = 16;
  localparam int GAP_W = 4;
`ifdef DATA_GEN_TX_LFSR_EN
  localparam bit LFSR_ON = 1'b1;
`else
  localparam bit LFSR_ON = 1'b0;
`endif

  logic             clk_i   = 1'b0;
  logic             reset_i = 1'b1;
  logic             start_i, abort_i, mode_i, ready_i;
  logic [CNT_W-1:0] count_i;
  logic [31:0]      seed_i;
  logic [GAP_W-1:0] gap_i;
  logic [31:0]      data_out_o;
  logic             valid_o, busy_o, done_o;
  logic [CNT_W-1:0] sent_o;

  always #5 clk_i = ~clk_i;

  data_gen_tx #(.CNT_W(CNT_W), .GAP_W(GAP_W)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .count_i(count_i), .seed_i(seed_i), .mode_i(mode_i), .gap_i(gap_i),
    .data_out_o(data_out_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .done_o(done_o), .sent_o(sent_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word k of a burst, computed straight from the sequence definition.
  function automatic logic [31:0] exp_word(input logic [31:0] s, input logic md, input int k);
    logic [31:0] w;
    if (!md) return s + 32'(k);
    w = (s == 32'h0) ? 32'h1 : s;
    for (int i = 0; i < k; i++) w = {1'b0, w[31:1]} ^ (w[0] ? 32'h8020_0003 : 32'h0);
    return w;
  endfunction

  // Reference model: burst bookkeeping in terms of words sent and idle cycles left.
  logic             m_valid = 1'b0, m_busy = 1'b0, m_done = 1'b0, m_mode = 1'b0;
  logic [CNT_W-1:0] m_sent = '0, m_count = '0;
  logic [GAP_W-1:0] m_gap = '0;
  logic [31:0]      m_seed = 32'h0;
  int               m_gap_left = 0;

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_sent <= '0; m_gap_left <= 0;
    end else if (!m_busy) begin
      if (start_i) begin
        m_seed  <= seed_i;
        m_mode  <= mode_i & LFSR_ON;
        m_count <= count_i;
        m_gap   <= gap_i;
        m_sent  <= '0;
        m_busy  <= 1'b1;
        if (count_i == '0) m_done <= 1'b1;
        else               m_valid <= 1'b1;
      end
    end else begin
      if (m_valid && ready_i) m_sent <= m_sent + 1'b1;
      if (abort_i) begin
        m_valid <= 1'b0; m_busy <= 1'b0; m_done <= 1'b0; m_gap_left <= 0;
      end else if (m_done) begin
        m_done <= 1'b0; m_busy <= 1'b0;
      end else if (m_valid) begin
        if (ready_i) begin
          if (int'(m_sent) + 1 == int'(m_count)) begin
            m_valid <= 1'b0; m_done <= 1'b1;
          end else if (m_gap != '0) begin
            m_valid <= 1'b0; m_gap_left <= int'(m_gap);
          end
        end
      end else if (m_gap_left == 1) begin
        m_gap_left <= 0; m_valid <= 1'b1;
      end else begin
        m_gap_left <= m_gap_left - 1;
      end
    end
  end

  bit          chk_en = 1'b0;
  int          start_n = 0;
  int          valid_seen = 0;
  logic [31:0] q_data[$];
  int          q_xrel[$];
  int          q_drel[$];

  always @(negedge clk_i) begin
    if (chk_en) begin
      check("valid", 32'(valid_o), 32'(m_valid));
      check("busy",  32'(busy_o),  32'(m_busy));
      check("done",  32'(done_o),  32'(m_done));
      check("sent",  32'(sent_o),  32'(m_sent));
      if (m_valid) check("data", data_out_o, exp_word(m_seed, m_mode, int'(m_sent)));
      if (valid_o) valid_seen++;
      if (valid_o && ready_i) begin
        q_data.push_back(data_out_o);
        q_xrel.push_back(cyc + 1 - start_n);
      end
      if (done_o) q_drel.push_back(cyc + 1 - start_n);
    end
  end

  task automatic check_word(input string name, input int idx, input logic [31:0] exp);
    check(name, (idx < q_data.size()) ? q_data[idx] : 32'hBAD0_BAD0, exp);
  endtask

  task automatic check_xrel(input string name, input int idx, input int exp);
    check(name, (idx < q_xrel.size()) ? 32'(q_xrel[idx]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic check_drel(input string name, input int exp);
    check({name, "_n"}, 32'(q_drel.size()), 32'd1);
    check(name, (q_drel.size() > 0) ? 32'(q_drel[0]) : 32'hFFFF_FFFF, 32'(exp));
  endtask

  task automatic start_burst(input logic [31:0] s, input int c, input logic md, input int g);
    @(posedge clk_i); #1;
    seed_i  = s;
    count_i = CNT_W'(c);
    mode_i  = md;
    gap_i   = GAP_W'(g);
    start_i = 1'b1;
    q_data.delete(); q_xrel.delete(); q_drel.delete();
    valid_seen = 0;
    @(posedge clk_i); #1;
    start_n = cyc;
    start_i = 1'b0;
    // Scramble the configuration; the running burst must not notice.
    seed_i  = 32'hDEAD_BEEF;
    count_i = '1;
    gap_i   = '1;
    mode_i  = ~md;
  endtask

  task automatic wait_idle(input bit toggle);
    int n = 0;
    while (busy_o && n < 500) begin
      @(posedge clk_i); #1;
      n++;
      if (toggle) ready_i = ~ready_i;
    end
    check("idle_timeout", 32'(busy_o), 32'd0);
    @(posedge clk_i); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    start_i = 1'b0; abort_i = 1'b0; count_i = '0; seed_i = 32'h0;
    mode_i = 1'b0; gap_i = '0; ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_data",  data_out_o,       32'h0);
    check("rst_valid", 32'(valid_o),     32'd0);
    check("rst_busy",  32'(busy_o),      32'd0);
    check("rst_done",  32'(done_o),      32'd0);
    check("rst_sent",  32'(sent_o),      32'd0);
    reset_i = 1'b0;
    chk_en  = 1'b1;

    // Incrementing burst wrapping through zero
    start_burst(32'hFFFF_FFFE, 4, 1'b0, 0);
    wait_idle(1'b0);
    check_word("inc_w0", 0, 32'hFFFF_FFFE);
    check_word("inc_w1", 1, 32'hFFFF_FFFF);
    check_word("inc_w2", 2, 32'h0000_0000);
    check_word("inc_w3", 3, 32'h0000_0001);
    check_xrel("inc_t0", 0, 1);
    check_xrel("inc_t3", 3, 4);
    check_drel("inc_done_at", 5);
    check("inc_sent", 32'(sent_o), 32'd4);

`ifdef DATA_GEN_TX_LFSR_EN
    start_burst(32'h1, 3, 1'b1, 0);
    wait_idle(1'b0);
    check_word("lfsr_w0", 0, 32'h0000_0001);
    check_word("lfsr_w1", 1, 32'h8020_0003);
    check_word("lfsr_w2", 2, 32'hC030_0002);
    start_burst(32'h0, 2, 1'b1, 0);
    wait_idle(1'b0);
    check_word("lfsr_seed0_w0", 0, 32'h0000_0001);
    check_word("lfsr_seed0_w1", 1, 32'h8020_0003);
`else
    start_burst(32'h1, 3, 1'b1, 0);
    wait_idle(1'b0);
    check_word("nolfsr_w0", 0, 32'h1);
    check_word("nolfsr_w1", 1, 32'h2);
    check_word("nolfsr_w2", 2, 32'h3);
`endif

    // Backpressure: ready toggles every cycle, starting low
    ready_i = 1'b0;
    start_burst(32'h100, 3, 1'b0, 0);
    wait_idle(1'b1);
    ready_i = 1'b1;
    check("bp_xfers", 32'(q_data.size()), 32'd3);
    check_word("bp_w2", 2, 32'h102);
    check_xrel("bp_t0", 0, 2);
    check_xrel("bp_t2", 2, 6);
    check_drel("bp_done_at", 7);

    // Inter-word gap of 2
    start_burst(32'h55, 3, 1'b0, 2);
    wait_idle(1'b0);
    check_xrel("gap_t0", 0, 1);
    check_xrel("gap_t1", 1, 4);
    check_xrel("gap_t2", 2, 7);
    check_word("gap_w2", 2, 32'h57);
    check_drel("gap_done_at", 8);

    // Zero-length burst
    start_burst(32'h77, 0, 1'b0, 0);
    wait_idle(1'b0);
    check("zero_valid_seen", 32'(valid_seen), 32'd0);
    check_drel("zero_done_at", 1);

    // Start pulsed mid-burst is ignored
    start_burst(32'h200, 5, 1'b0, 1);
    @(posedge clk_i); #1;
    start_i = 1'b1; seed_i = 32'h999; count_i = CNT_W'(2);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    wait_idle(1'b0);
    check("mid_xfers", 32'(q_data.size()), 32'd5);
    check_word("mid_w4", 4, 32'h204);
    check_drel("mid_done_at", 10);

    // Abort on the edge of the second transfer
    start_burst(32'h300, 10, 1'b0, 0);
    @(posedge clk_i); #1;
    abort_i = 1'b1;
    @(posedge clk_i); #1;
    abort_i = 1'b0;
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_busy",  32'(busy_o),  32'd0);
    check("abort_sent",  32'(sent_o),  32'd2);
    repeat (3) @(posedge clk_i);
    #1;
    check("abort_no_done", 32'(q_drel.size()), 32'd0);
    check("abort_sent_held", 32'(sent_o), 32'd2);
    start_burst(32'h400, 1, 1'b0, 0);
    wait_idle(1'b0);
    check_word("after_abort_w0", 0, 32'h400);
    check_drel("after_abort_done_at", 2);

    // Asynchronous reset in the middle of a burst
    start_burst(32'h500, 10, 1'b0, 0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i); #1;
    reset_i = 1'b1;
    #1;
    check("areset_data",  data_out_o,   32'h0);
    check("areset_valid", 32'(valid_o), 32'd0);
    check("areset_busy",  32'(busy_o),  32'd0);
    check("areset_sent",  32'(sent_o),  32'd0);
    @(negedge clk_i); #1;
    reset_i = 1'b0;
    check("areset_no_done", 32'(q_drel.size()), 32'd0);
    start_burst(32'h600, 2, 1'b0, 0);
    wait_idle(1'b0);
    check_word("post_reset_w1", 1, 32'h601);
    check_drel("post_reset_done_at", 3);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/data_gen_tx.md
# data_gen_tx

Transmit-side stimulus generator for the 32-bit data path of the `dummy` DUT. It produces a programmable burst of data words, either incrementing or pseudo-random, on a valid/ready handshake with optional idle gaps between words. It sits in the bench, or in a wrapper, upstream of the receiving block's data input, and reports progress and completion to the controlling stimulus code.

## Interface
Parameters:
- `CNT_W`, default 16: width of the burst word count and sent counter.
- `GAP_W`, default 4: width of the inter-word gap setting.

Ports:
- `clk_i`  in  1  clock, rising edge.
- `reset_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  start a burst; sampled only in IDLE.
- `abort_i`  in  1  terminate the current burst.
- `count_i`  in  CNT_W  number of words in the burst; captured at start.
- `seed_i`  in  32  first word value; captured at start.
- `mode_i`  in  1  0 = incrementing, 1 = LFSR; captured at start.
- `gap_i`  in  GAP_W  idle cycles after each non-last transfer; captured at start.
- `data_out_o`  out  32  current word.
- `valid_o`  out  1  `data_out_o` is valid.
- `ready_i`  in  1  downstream accepts the word.
- `busy_o`  out  1  burst in progress.
- `done_o`  out  1  one-cycle pulse when a burst completes normally.
- `sent_o`  out  CNT_W  words transferred in the current or last burst.

## Operation
- FSM states: IDLE, SEND, GAP, DONE. All outputs are registered.
- IDLE, `start_i`=1:
  - Capture the configuration inputs and clear `sent_o`.
  - If `count_i`=0, go to DONE.
  - Otherwise go to SEND with `data_out_o` = word 0.
- SEND: `valid_o`=1. A transfer occurs on an edge where `valid_o` and `ready_i` are both 1.
  - On a transfer, `sent_o` increments.
  - Last word (`sent_o`+1 = count): go to DONE.
  - Otherwise, if gap=0, stay in SEND with the next word; else go to GAP.
- GAP: `valid_o`=0 for exactly gap cycles, then SEND with the next word.
- DONE: `done_o`=1 for one cycle, `valid_o`=0, then IDLE.
- Word sequence:
  - Incrementing: word k = (seed + k) mod 2^32.
  - LFSR: word 0 = seed, or 32'h1 if seed = 0. Next word = {1'b0, d[31:1]} ^ (d[0] ? 32'h80200003 : 32'h0).
- `data_out_o` and `valid_o` are held stable while `valid_o`=1 and `ready_i`=0.
- `abort_i`=1 in SEND, GAP or DONE: next state is IDLE, `valid_o`=0, no `done_o`, `sent_o` keeps its value. Abort takes priority over a same-cycle transfer, but that transfer is still counted.
- `start_i` outside IDLE is ignored. Config input changes after start are ignored.
- `busy_o` = 1 in SEND, GAP and DONE.

## Timing
- Reset values: `data_out_o`=0, `valid_o`=0, `busy_o`=0, `done_o`=0, `sent_o`=0, state IDLE. Reset is asynchronous and effective mid-burst; no completion is signalled.
- `start_i` at edge N gives `valid_o`=1 and `busy_o`=1 after edge N.
- With `ready_i` held at 1 and gap=0: one word per cycle. A burst of C words gives `done_o` in cycle N+C+1.
- With gap=G: transfers are spaced G+1 cycles apart.
- `count_i`=0: `busy_o` and `done_o` are both 1 in the cycle after start, then IDLE. `valid_o` never asserts.
- `sent_o` wraps at 2^CNT_W only if `count_i`=0 overflow is impossible. The maximum burst is 2^CNT_W−1 words.
- A new start is accepted in the first IDLE cycle after DONE, giving back-to-back bursts with a 1-cycle gap.

## Configuration
- `DATA_GEN_TX_LFSR_EN` defined: LFSR mode is available, selected by `mode_i`=1.
- `DATA_GEN_TX_LFSR_EN` undefined: the LFSR logic is not compiled, `mode_i` is ignored and always treated as 0 (incrementing).

## Test plan
- Incrementing burst: seed 32'hFFFFFFFE, count 4, gap 0, `ready_i`=1 → words FFFFFFFE, FFFFFFFF, 00000000, 00000001 on consecutive cycles; `done_o` at start+5; `sent_o`=4.
- LFSR burst (macro defined): seed 32'h1, count 3 → 00000001, 80200003, C0300002. With seed 0 the first word is 00000001. With the macro undefined, seed 1 gives 1, 2, 3.
- Backpressure: count 3, `ready_i` toggling 0/1 every cycle → each word held stable while `ready_i`=0; exactly 3 transfers; `done_o` once.
- Gap: count 3, gap 2, `ready_i`=1 → transfers at start+1, +4, +7; `valid_o` low for 2 cycles between transfers.
- Boundary: count 0 → `valid_o` never high, `done_o` pulse at start+1. `start_i` pulsed mid-burst → ignored.
- Abort and reset: `abort_i` after 2 transfers of a 10-word burst → `valid_o` low next cycle, no `done_o`, `sent_o`=2, next start accepted. Async `reset_i` mid-burst → all outputs 0 immediately.
